regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised register file for the next pipeline generation.
- Configurable data width, register count and number of read ports.
- Register 0 is hardwired to zero; the write port is synchronous.
- A per-register busy scoreboard lets the decode stage detect RAW hazards on in-flight results. The block sits between decode (reads, issue marking) and writeback (writes, busy clearing).

Parameters:
- DATA_W, 32: register width in bits.
- NUM_REGS, 16: number of architectural registers; power of two, at least 4.
- NUM_RD, 3: number of independent read ports, 1 to 4.
- ADDR_W, $clog2(NUM_REGS): register address width. Derived; never overridden.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: asynchronous active-high reset.
- rd_addr, in, NUM_RD*ADDR_W: packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data, out, NUM_RD*DATA_W: packed read data, combinational.
- rd_busy, out, NUM_RD: per-port busy flag of the addressed register, combinational.
- hazard, out, 1: OR of rd_busy over ports whose rd_use bit is set.
- rd_use, in, NUM_RD: per-port "operand actually used" qualifier for hazard.
- wr_en, in, 1: writeback strobe.
- wr_addr, in, ADDR_W: writeback register.
- wr_data, in, DATA_W: writeback data.
- iss_en, in, 1: issue strobe; marks iss_addr busy.
- iss_addr, in, ADDR_W: destination register of the issuing instruction.
- flush, in, 1: synchronous clear of all busy bits (pipeline flush).
- busy_cnt, out, ADDR_W+1: registered count of busy registers.

Behaviour:
- Reset (async, rst=1):
  - all registers = 0, all busy bits = 0, busy_cnt = 0.
  - rd_data therefore reads 0 and hazard = 0 while reset is held.
- Reads:
  - Purely combinational from current state.
  - Address 0 always returns 0 with rd_busy = 0.
  - Any in-range address returns the stored value.
- Write:
  - On a clk rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
  - wr_addr=0 is ignored; no state changes.
  - Write latency is 1 cycle: the new value is visible to reads in the cycle after the edge, unless bypass is enabled (see Optional Feature).
- Busy scoreboard, per register r != 0, evaluated at each edge, priority top to bottom:
  1. flush=1: busy[r] <= 0 for all r, overriding iss_en and wr_en clears. A write with wr_en still updates data.
  2. iss_en=1 and iss_addr==r: busy[r] <= 1. This applies even if wr_en with wr_addr==r occurs in the same cycle: a new producer supersedes the retiring one.
  3. wr_en=1 and wr_addr==r: busy[r] <= 0.
  4. Otherwise busy[r] holds.
- iss_en with iss_addr=0 has no effect; busy[0] is constantly 0.
- busy_cnt:
  - Registered population count of the busy vector, updated on the same edge as busy.
  - Range 0 to NUM_REGS-1; no wrap.
- Issuing an already-busy register keeps it busy and leaves the count unchanged.
- Writeback to a non-busy register writes data and leaves busy at 0.
- Reset asserted mid-operation clears everything immediately, regardless of clk. Release is synchronous to the design only via the register elements; no extra sequencing.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If wr_en=1, wr_addr!=0 and rd_addr[i]==wr_addr, rd_data[i] = wr_data combinationally in the same cycle.
  - rd_busy[i] for that port is forced to 0, unless iss_en targets the same register in that cycle (issue precedence retained).
- Undefined: reads see only stored state. A same-cycle write is visible the next cycle and busy drops the next cycle.

Test Plan:
- Reset, then write 0xDEADBEEF to r5, and read r5 on all ports next cycle -> 0xDEADBEEF on every port; r0 reads 0.
- wr_en to r0 with 0x12345678, then read r0 -> 0; iss_en to r0 -> busy_cnt stays 0.
- iss_en r3, read r3 with rd_use[0]=1 -> rd_busy[0]=1, hazard=1, busy_cnt=1; next cycle wr_en r3 = 0x55 -> following cycle busy clear, hazard=0, rd_data=0x55.
- Same cycle iss_en r7 and wr_en r7=0xAA -> r7=0xAA, busy[7]=1, busy_cnt +1.
- iss_en r1, r2, r4 on consecutive cycles (busy_cnt=3), then flush together with wr_en r9=0x9 -> busy_cnt=0, r9=0x9.
- With REGFILE_BYPASS_EN: wr_en r6=0x77 while rd_addr[1]=6 -> rd_data[1]=0x77 in the same cycle. Without the macro -> old value this cycle, 0x77 the next. Assert rst mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the scoreboarded register file.
// master = pipeline side, slave = register file.
interface regfile_scoreboard_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 3
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_RD-1:0]        rd_use;
    logic                     hazard;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_addr, rd_use, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, hazard, busy_cnt
    );

    modport slave (
        input  rd_addr, rd_use, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, hazard, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with r0 hardwired to zero and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [ADDR_W:0]     busy_cnt_q;
    logic [ADDR_W-1:0]   rd_a [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;

    function automatic logic [ADDR_W:0] popcnt(input logic [NUM_REGS-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int k = 0; k < NUM_REGS; k++) c = c + {{ADDR_W{1'b0}}, v[k]};
        return c;
    endfunction

    // Flush beats issue, and issue beats a retiring write to the same register.
    always_comb begin
        busy_next = busy;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (bus.flush)
                busy_next[r] = 1'b0;
            else if (bus.iss_en && (bus.iss_addr == ADDR_W'(r)))
                busy_next[r] = 1'b1;
            else if (bus.wr_en && (bus.wr_addr == ADDR_W'(r)))
                busy_next[r] = 1'b0;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (bus.wr_en && (bus.wr_addr != '0))
                regs[bus.wr_addr] <= bus.wr_data;
            busy       <= busy_next;
            busy_cnt_q <= popcnt(busy_next);
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_addr
        assign rd_a[g] = bus.rd_addr[g*ADDR_W +: ADDR_W];
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_a[i] != '0) begin
                rd_data_c[i*DATA_W +: DATA_W] = regs[rd_a[i]];
                rd_busy_c[i]                  = busy[rd_a[i]];
            end
`ifdef REGFILE_BYPASS_EN
            // Forward the retiring value; a same-cycle issue to it keeps the port busy.
            if (bus.wr_en && (bus.wr_addr != '0) && (rd_a[i] == bus.wr_addr)) begin
                rd_data_c[i*DATA_W +: DATA_W] = bus.wr_data;
                if (!(bus.iss_en && (bus.iss_addr == bus.wr_addr)))
                    rd_busy_c[i] = 1'b0;
            end
`endif
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.hazard   = |(rd_busy_c & bus.rd_use);
    assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: vector table plus hand sequences for
// saturation, async reset and same-cycle write visibility.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) bus ();

    regfile_scoreboard #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        wr_en;
        logic [3:0]  wr_addr;
        logic [31:0] wr_data;
        logic        iss_en;
        logic [3:0]  iss_addr;
        logic        flush;
        logic [3:0]  ra0, ra1, ra2;
        logic [2:0]  rdu;
        logic [31:0] e0, e1, e2;
        logic [2:0]  ebusy;
        logic        ehaz;
        logic [4:0]  ecnt;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0; bus.flush = 1'b0;
    endtask

    task automatic set_reads(input logic [3:0] a0, a1, a2, input logic [2:0] u);
        bus.rd_addr = {a2, a1, a0};
        bus.rd_use  = u;
    endtask

    // Clock one edge with the currently driven strobes, then drop them.
    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        set_reads(4'd0, 4'd0, 4'd0, 3'b000);

        //          wr  wa  wdata         iss ia  fl  ra0 ra1 ra2  use     e0            e1            e2        busy   hz  cnt
        vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0,  0,  5,  5,  5, 3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 0, 0};
        vecs[1]  = '{1, 0, 32'h12345678, 0, 0,  0,  0,  0,  5, 3'b111, 32'h0,        32'h0,        32'hDEADBEEF, 3'b000, 0, 0};
        vecs[2]  = '{0, 0, 32'h0,        1, 0,  0,  0,  5,  0, 3'b111, 32'h0,        32'hDEADBEEF, 32'h0,        3'b000, 0, 0};
        vecs[3]  = '{0, 0, 32'h0,        1, 3,  0,  3,  5,  0, 3'b001, 32'h0,        32'hDEADBEEF, 32'h0,        3'b001, 1, 1};
        vecs[4]  = '{1, 3, 32'h55,       0, 0,  0,  3,  3,  0, 3'b001, 32'h55,       32'h55,       32'h0,        3'b000, 0, 0};
        vecs[5]  = '{1, 7, 32'hAA,       1, 7,  0,  7,  3,  0, 3'b000, 32'hAA,       32'h55,       32'h0,        3'b001, 0, 1};
        vecs[6]  = '{0, 0, 32'h0,        1, 1,  0,  1,  7,  0, 3'b010, 32'h0,        32'hAA,       32'h0,        3'b011, 1, 2};
        vecs[7]  = '{0, 0, 32'h0,        1, 2,  0,  2,  1,  7, 3'b100, 32'h0,        32'h0,        32'hAA,       3'b111, 1, 3};
        vecs[8]  = '{0, 0, 32'h0,        1, 4,  0,  4,  2,  0, 3'b000, 32'h0,        32'h0,        32'h0,        3'b011, 0, 4};
        vecs[9]  = '{1, 9, 32'h9,        1, 10, 1,  9,  4, 10, 3'b111, 32'h9,        32'h0,        32'h0,        3'b000, 0, 0};
        vecs[10] = '{0, 0, 32'h0,        1, 4,  0,  4,  0,  0, 3'b001, 32'h0,        32'h0,        32'h0,        3'b001, 1, 1};
        vecs[11] = '{0, 0, 32'h0,        1, 4,  0,  4,  0,  0, 3'b001, 32'h0,        32'h0,        32'h0,        3'b001, 1, 1};
        vecs[12] = '{1, 2, 32'h22,       0, 0,  0,  2,  4,  0, 3'b010, 32'h22,       32'h0,        32'h0,        3'b010, 1, 1};
        vecs[13] = '{1, 4, 32'h44,       0, 0,  0,  4,  2,  0, 3'b011, 32'h44,       32'h22,       32'h0,        3'b000, 0, 0};

        // Reset held: everything reads zero.
        set_reads(4'd5, 4'd3, 4'd0, 3'b111);
        #3;
        check("reset_rd_data", bus.rd_data[31:0], 32'h0);
        check("reset_hazard", {31'h0, bus.hazard}, 32'h0);
        check("reset_busy_cnt", {27'h0, bus.busy_cnt}, 32'h0);
        #9 rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            bus.wr_en = vecs[i].wr_en; bus.wr_addr = vecs[i].wr_addr; bus.wr_data = vecs[i].wr_data;
            bus.iss_en = vecs[i].iss_en; bus.iss_addr = vecs[i].iss_addr; bus.flush = vecs[i].flush;
            set_reads(vecs[i].ra0, vecs[i].ra1, vecs[i].ra2, vecs[i].rdu);
            step();
            check($sformatf("v%0d_rd0", i), bus.rd_data[31:0], vecs[i].e0);
            check($sformatf("v%0d_rd1", i), bus.rd_data[63:32], vecs[i].e1);
            check($sformatf("v%0d_rd2", i), bus.rd_data[95:64], vecs[i].e2);
            check($sformatf("v%0d_busy", i), {29'h0, bus.rd_busy}, {29'h0, vecs[i].ebusy});
            check($sformatf("v%0d_hazard", i), {31'h0, bus.hazard}, {31'h0, vecs[i].ehaz});
            check($sformatf("v%0d_cnt", i), {27'h0, bus.busy_cnt}, {27'h0, vecs[i].ecnt});
        end

        // Fill the scoreboard: count climbs to NUM_REGS-1 and does not wrap.
        set_reads(4'd15, 4'd0, 4'd0, 3'b001);
        for (int r = 1; r < 16; r++) begin
            bus.iss_en = 1'b1; bus.iss_addr = 4'(r);
            step();
            check($sformatf("fill_cnt_%0d", r), {27'h0, bus.busy_cnt}, r);
        end
        check("fill_hazard", {31'h0, bus.hazard}, 32'h1);
        bus.iss_en = 1'b1; bus.iss_addr = 4'd5;
        step();
        check("reissue_cnt", {27'h0, bus.busy_cnt}, 32'd15);
        bus.wr_en = 1'b1; bus.wr_addr = 4'd15; bus.wr_data = 32'hF0F0;
        bus.iss_en = 1'b1; bus.iss_addr = 4'd0;
        step();
        check("retire_cnt", {27'h0, bus.busy_cnt}, 32'd14);
        check("retire_rd0", bus.rd_data[31:0], 32'hF0F0);
        check("retire_busy0", {31'h0, bus.rd_busy[0]}, 32'h0);

        // Async reset mid-operation, away from any clock edge.
        set_reads(4'd5, 4'd15, 4'd9, 3'b111);
        #2 rst = 1'b1;
        #1;
        check("midrst_rd0", bus.rd_data[31:0], 32'h0);
        check("midrst_rd1", bus.rd_data[63:32], 32'h0);
        check("midrst_rd2", bus.rd_data[95:64], 32'h0);
        check("midrst_busy", {29'h0, bus.rd_busy}, 32'h0);
        check("midrst_hazard", {31'h0, bus.hazard}, 32'h0);
        check("midrst_cnt", {27'h0, bus.busy_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Same-cycle write visibility on port 1.
        set_reads(4'd0, 4'd6, 4'd0, 3'b010);
        bus.wr_en = 1'b1; bus.wr_addr = 4'd6; bus.wr_data = 32'h11;
        step();
        bus.iss_en = 1'b1; bus.iss_addr = 4'd6;
        step();
        check("pre_bypass_busy", {31'h0, bus.rd_busy[1]}, 32'h1);
        bus.wr_en = 1'b1; bus.wr_addr = 4'd6; bus.wr_data = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_rd1", bus.rd_data[63:32], 32'h77);
        check("same_cycle_busy1", {31'h0, bus.rd_busy[1]}, 32'h0);
        check("same_cycle_hazard", {31'h0, bus.hazard}, 32'h0);
`else
        check("same_cycle_rd1", bus.rd_data[63:32], 32'h11);
        check("same_cycle_busy1", {31'h0, bus.rd_busy[1]}, 32'h1);
        check("same_cycle_hazard", {31'h0, bus.hazard}, 32'h1);
`endif
        bus.iss_en = 1'b1; bus.iss_addr = 4'd6;
        #1;
        check("same_cycle_iss_busy1", {31'h0, bus.rd_busy[1]}, 32'h1);
        bus.iss_en = 1'b0;
        step();
        check("next_cycle_rd1", bus.rd_data[63:32], 32'h77);
        check("next_cycle_busy1", {31'h0, bus.rd_busy[1]}, 32'h0);
        check("next_cycle_cnt", {27'h0, bus.busy_cnt}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
